// File: rtl/serial_sum_collector_pkg.sv
// serial_sum_collector_pkg: shared state encoding and default sizes for the serial adder datapath
package serial_sum_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PUSH  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/serial_sum_collector_sum_fifo.sv
// sum_fifo: first-word-fall-through FIFO holding completed result words
module sum_fifo
    import serial_sum_collector_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH + 1,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_pop, do_push;

    assign empty   = count_q == '0;
    assign full    = count_q == (PTR_W+1)'(DEPTH);
    assign count   = count_q;
    assign dout    = empty ? '0 : mem[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // a full FIFO still accepts a word when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);

    // pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    // control registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage is left unreset; out_data is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/serial_sum_collector.sv
// serial_sum_collector: deserializes LSB-first sum bits plus carry into words and queues them
module serial_sum_collector
    import serial_sum_collector_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             carry_in,
    output logic [WIDTH:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PTR_W:0]   count,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clr_status
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH:0]   word_q, word_d;
    logic             overflow_q, overflow_d, frame_err_q, frame_err_d;
    logic             fe_set, push, pop, full, empty;

    assign shifted   = {bit_in, shreg_q[WIDTH-1:1]};
    assign push      = state_q == ST_PUSH;
    assign pop       = out_ready & ~empty;
    assign out_valid = ~empty;
    assign busy      = state_q != ST_IDLE;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

    // deserializer next state; a frame_start mid-word restarts on that bit
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        fe_set    = 1'b0;
        case (state_q)
            ST_IDLE: if (bit_valid && frame_start) begin
                shreg_d   = shifted;
                bit_cnt_d = CNT_W'(1);
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: if (bit_valid) begin
                shreg_d = shifted;
                if (frame_start) begin
                    bit_cnt_d = CNT_W'(1);
                    fe_set    = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        word_d  = {carry_in, shifted};
                        state_d = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                bit_cnt_d = '0;
                fe_set    = bit_valid;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        overflow_d  = (push & full & ~pop) | (overflow_q & ~clr_status);
        frame_err_d = fe_set | (frame_err_q & ~clr_status);
    end

    // deserializer and status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    sum_fifo #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (word_q),
        .dout  (out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_serial_sum_collector.sv
// tb_serial_sum_collector: directed, table-driven and random checks against a queue-based model
module tb_serial_sum_collector;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 0, rst_n = 0;
    logic             bit_in = 0, bit_valid = 0, frame_start = 0, carry_in = 0;
    logic             out_ready = 0, clr_status = 0;
    logic [WIDTH:0]   out_data;
    logic             out_valid, busy, overflow, frame_err;
    logic [PTR_W:0]   count;

    int total = 0, bad = 0;

    logic           m_bits [$];
    logic [WIDTH:0] m_q [$];
    logic           m_active = 0, m_pend = 0, m_ov = 0, m_fe = 0;
    logic [WIDTH:0] m_word = 0;

    typedef struct {
        logic [7:0] sum;
        logic       carry;
        int         gap;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [4];

    serial_sum_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .carry_in    (carry_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .busy        (busy),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .clr_status  (clr_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // reference: words are lists of collected bits; a completed word waits one cycle, then enters the queue
    task automatic model_step();
        logic ov_set = 0, fe_set = 0;
        if (!rst_n) begin
            m_bits.delete(); m_q.delete();
            m_active = 0; m_pend = 0; m_ov = 0; m_fe = 0;
            return;
        end
        if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (m_pend) begin
            if (bit_valid) fe_set = 1;
            if (m_q.size() < DEPTH) m_q.push_back(m_word); else ov_set = 1;
            m_pend = 0;
        end else if (bit_valid) begin
            if (frame_start) begin
                if (m_active) fe_set = 1;
                m_bits.delete();
                m_bits.push_back(bit_in);
                m_active = 1;
            end else if (m_active) m_bits.push_back(bit_in);
            if (m_active && m_bits.size() == WIDTH) begin
                m_word = 0;
                for (int i = 0; i < WIDTH; i++) m_word[i] = m_bits[i];
                m_word[WIDTH] = carry_in;
                m_pend = 1; m_active = 0;
            end
        end
        m_ov = ov_set | (m_ov & ~clr_status);
        m_fe = fe_set | (m_fe & ~clr_status);
    endtask

    task automatic cmp_model();
        chk("m_out_data", 32'(out_data), m_q.size() > 0 ? 32'(m_q[0]) : 32'd0);
        chk("m_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("m_count", 32'(count), 32'(m_q.size()));
        chk("m_busy", 32'(busy), 32'(m_active | m_pend));
        chk("m_overflow", 32'(overflow), 32'(m_ov));
        chk("m_frame_err", 32'(frame_err), 32'(m_fe));
    endtask

    task automatic cyc(input logic bv, input logic fs, input logic b, input logic c,
                       input logic rdy, input logic clr);
        bit_valid = bv; frame_start = fs; bit_in = b; carry_in = c;
        out_ready = rdy; clr_status = clr;
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic idle(input logic rdy);
        cyc(0, 0, 0, 0, rdy, 0);
    endtask

    task automatic send_bits(input logic [7:0] s, input logic c, input int gap, input logic rdy);
        for (int i = 0; i < WIDTH; i++) begin
            if (i != 0) repeat (gap) idle(rdy);
            cyc(1, i == 0, s[i], (i == WIDTH - 1) ? c : 1'b0, rdy, 0);
        end
    endtask

    initial begin
        vecs[0] = '{8'h96, 1'b0, 0, 9'h096};
        vecs[1] = '{8'h00, 1'b1, 3, 9'h100};
        vecs[2] = '{8'hFF, 1'b1, 1, 9'h1FF};
        vecs[3] = '{8'h81, 1'b0, 2, 9'h081};

        rst_n = 0;
        idle(0); idle(0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1;
        idle(0);

        // 1: 0x5A+0x3C -> 0x096, visible two cycles after the last bit
        send_bits(8'h96, 0, 0, 0);
        chk("t1_valid_last", 32'(out_valid), 0);
        idle(0);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_data", 32'(out_data), 32'h096);
        chk("t1_count", 32'(count), 1);
        idle(1);

        // 2: 0xFF+0x01 with gaps -> 0x100
        send_bits(8'h00, 1, 3, 0);
        chk("t2_busy", 32'(busy), 1);
        idle(0);
        chk("t2_data", 32'(out_data), 32'h100);
        chk("t2_frame_err", 32'(frame_err), 0);
        idle(1);

        // 3: overflow on the fifth word
        for (int w = 1; w <= 5; w++) begin
            send_bits(8'(w), 0, 0, 0);
            idle(0);
        end
        chk("t3_count", 32'(count), 4);
        chk("t3_overflow", 32'(overflow), 1);
        for (int w = 1; w <= 4; w++) begin
            chk("t3_pop_data", 32'(out_data), 32'(w));
            idle(1);
        end
        cyc(0, 0, 0, 0, 0, 1);
        chk("t3_clr", 32'(overflow), 0);

        // 4: full FIFO, pop and push in the same cycle
        for (int w = 0; w < 4; w++) begin
            send_bits(8'h11 + 8'(w), 0, 0, 0);
            idle(0);
        end
        send_bits(8'hAA, 0, 0, 0);
        idle(1);
        chk("t4_count", 32'(count), 4);
        chk("t4_overflow", 32'(overflow), 0);
        for (int w = 0; w < 3; w++) begin
            chk("t4_pop_data", 32'(out_data), 32'h12 + 32'(w));
            idle(1);
        end
        chk("t4_last", 32'(out_data), 32'h0AA);
        idle(1);

        // 5: restart after 4 bits
        for (int i = 0; i < 4; i++) cyc(1, i == 0, 1'b1, 0, 0, 0);
        send_bits(8'h33, 0, 0, 0);
        idle(0);
        chk("t5_frame_err", 32'(frame_err), 1);
        chk("t5_count", 32'(count), 1);
        chk("t5_data", 32'(out_data), 32'h033);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1);

        // 6: reset mid-frame with words buffered
        for (int w = 0; w < 2; w++) begin
            send_bits(8'h40 + 8'(w), 0, 0, 0);
            idle(0);
        end
        for (int i = 0; i < 3; i++) cyc(1, i == 0, 1'b1, 0, 0, 0);
        rst_n = 0;
        idle(0);
        chk("t6_count", 32'(count), 0);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_data", 32'(out_data), 0);
        chk("t6_busy", 32'(busy), 0);
        rst_n = 1;
        send_bits(8'h5A, 0, 0, 0);
        idle(0);
        chk("t6_after", 32'(out_data), 32'h05A);
        chk("t6_after_cnt", 32'(count), 1);
        idle(1);

        // table-driven vectors
        foreach (vecs[k]) begin
            send_bits(vecs[k].sum, vecs[k].carry, vecs[k].gap, 0);
            idle(0);
            chk("tbl_data", 32'(out_data), 32'(vecs[k].exp));
            chk("tbl_count", 32'(count), 1);
            idle(1);
        end

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, 1'($urandom),
                1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
        end
        rst_n = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
